note_hist_ctrl: RTL and testbench
=================================

NOTE_HIST_CTRL -- requirements
Module: note_hist_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000000, idle cycles before history auto-clear (used only with macro, REQ-024).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port code_valid  input  1  one-cycle strobe, PS/2 byte present on code.
REQ-005 SHALL have port code  input  8  PS/2 set-2 scan byte, sampled only when code_valid=1.
REQ-006 SHALL have port clear  input  1  synchronous history/held-key clear.
REQ-007 SHALL have port disp_word  output  32  last four note scan codes, newest in [7:0], oldest in [31:24], feeds 7-seg decoder x input.
REQ-008 SHALL have port hist_count  output  3  valid entries in disp_word, 0..4, saturating.
REQ-009 SHALL have port key_held  output  1  a note key is currently pressed.
REQ-010 SHALL have port held_code  output  8  scan code of held key, 8'h00 when none.
REQ-011 SHALL have port note_strobe  output  1  one-cycle pulse per new note press.

Function
REQ-012 SHALL recognise exactly 21 note codes: 15 1D 24 2D 2C 35 3C, 1C 1B 23 2B 34 33 3B, 1A 22 21 2A 32 31 3A (hex); all other bytes are non-note.
REQ-013 SHALL run FSM S_IDLE, S_BRK, S_EXT, S_EXT_BRK, advancing only on code_valid.
REQ-014 S_IDLE: F0 -> S_BRK; E0 -> S_EXT; note make -> REQ-015; other -> stay, ignored.
REQ-015 Note make when key_held=1 and code==held_code SHALL be typematic repeat: no push, no strobe; otherwise push disp_word<={disp_word[23:0],code}, hist_count+1 saturating at 4, held_code<=code, key_held<=1, note_strobe=1.
REQ-016 S_BRK: F0 -> stay; E0 -> S_EXT; any other byte -> S_IDLE, and if byte==held_code then key_held<=0, held_code<=8'h00; release of non-held key changes nothing else.
REQ-017 S_EXT: F0 -> S_EXT_BRK; any other -> S_IDLE, byte ignored. S_EXT_BRK: any byte -> S_IDLE, ignored.
REQ-018 All outputs SHALL be registered; effect visible the cycle after the sampling edge (latency 1); note_strobe high exactly one cycle.
REQ-019 clear=1 SHALL set disp_word=0, hist_count=0, key_held=0, held_code=0, state S_IDLE next cycle; clear wins over a simultaneous code_valid (byte dropped, no strobe).
REQ-020 Fifth and later pushes SHALL discard oldest byte; hist_count stays 4.

Reset
REQ-021 rst_n=0 SHALL immediately force S_IDLE, disp_word=32'h0, hist_count=0, key_held=0, held_code=8'h00, note_strobe=0, timeout counter=0, regardless of clk.
REQ-022 Reset mid-sequence (e.g. after F0) SHALL discard pending prefix; first byte after release is decoded from S_IDLE.
REQ-023 Release SHALL be synchronised to clk by the integrating top level, not inside this block.

Configuration
REQ-024 With NOTE_HIST_TIMEOUT_EN defined: counter clears on every code_valid, else increments; when it reaches TIMEOUT_CYCLES-1 with key_held=0 and hist_count!=0, disp_word and hist_count SHALL clear next cycle and counter restarts at 0; counter holds while key_held=1.
REQ-025 Without NOTE_HIST_TIMEOUT_EN: no counter logic exists; history persists until clear or reset; TIMEOUT_CYCLES unused.

Structure
REQ-026 Package note_pkg SHALL hold the 21 note-code constants, F0/E0 prefix constants, FSM state type, history depth (4).
REQ-027 One sub-module note_key_decode SHALL be combinational: code in, is_note out.

Verification
REQ-028 Reset, then 1C -> disp_word=32'h0000001C, hist_count=1, key_held=1, held_code=1C, one note_strobe.
REQ-029 1C,1C,1C (repeat) then F0,1C -> single strobe, disp_word unchanged, key_held=0, held_code=00.
REQ-030 Presses 15,F0,15,1D,F0,1D,24,F0,24,2D,F0,2D,2C,F0,2C -> disp_word=32'h1D242D2C, hist_count=4, five strobes.
REQ-031 E0,75 then E0,F0,75 then F0 then 22 -> E0 sequences ignored; after F0 the 22 is a release, disp_word unchanged, no strobe.
REQ-032 clear and code_valid (code=1A) same cycle -> all outputs zero, no strobe; rst_n low after F0 then 1A -> 1A pushed as make.
REQ-033 NOTE_HIST_TIMEOUT_EN, TIMEOUT_CYCLES=16: press/release 3B, idle 16 cycles -> disp_word=0, hist_count=0; same with 3B held -> history retained.

Source files
------------

// File: rtl/note_pkg.sv
// Shared constants and types for the note history controller: PS/2 set-2 note
// codes, break/extended prefixes, decoder FSM states and history depth.
package note_pkg;

    localparam int unsigned HIST_DEPTH = 4;
    localparam int unsigned NUM_NOTES  = 21;

    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_EXT = 8'hE0;

    // Three keyboard rows, seven notes each, low octave first
    localparam logic [7:0] NOTE_CODES [NUM_NOTES] = '{
        8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C,
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B,
        8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_BRK,
        S_EXT,
        S_EXT_BRK
    } state_t;

    function automatic logic is_note_code(input logic [7:0] c);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_NOTES; i++) begin
            if (c == NOTE_CODES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/note_key_decode.sv
// Combinational classifier: flags whether a scan byte is one of the note keys.
module note_key_decode
    import note_pkg::*;
(
    input  logic [7:0] code,
    output logic       is_note
);

    assign is_note = is_note_code(code);

endmodule

// File: rtl/note_hist_ctrl.sv
// PS/2 note-key tracker: keeps the last four pressed note codes for display,
// tracks the held key and strobes once per new press.
// Optional idle auto-clear of the history is enabled by NOTE_HIST_TIMEOUT_EN.
module note_hist_ctrl
    import note_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        code_valid,
    input  logic [7:0]  code,
    input  logic        clear,
    output logic [31:0] disp_word,
    output logic [2:0]  hist_count,
    output logic        key_held,
    output logic [7:0]  held_code,
    output logic        note_strobe
);

    state_t      state_q, state_d;
    logic [31:0] disp_q, disp_d;
    logic [2:0]  hist_q, hist_d;
    logic        held_q, held_d;
    logic [7:0]  hcode_q, hcode_d;
    logic        strobe_q, strobe_d;
    logic        is_note;
    logic        timeout_hit;

    note_key_decode u_decode (
        .code    (code),
        .is_note (is_note)
    );

`ifdef NOTE_HIST_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_q;
    logic          tmo_end;

    assign tmo_end     = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign timeout_hit = tmo_end && !held_q && (hist_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          tmo_q <= '0;
        else if (code_valid) tmo_q <= '0;
        else if (held_q)     tmo_q <= tmo_q;
        else if (tmo_end)    tmo_q <= '0;
        else                 tmo_q <= tmo_q + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_d  = state_q;
        disp_d   = disp_q;
        hist_d   = hist_q;
        held_d   = held_q;
        hcode_d  = hcode_q;
        strobe_d = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
            disp_d  = '0;
            hist_d  = '0;
            held_d  = 1'b0;
            hcode_d = '0;
        end else if (code_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (code == CODE_BRK)      state_d = S_BRK;
                    else if (code == CODE_EXT) state_d = S_EXT;
                    else if (is_note && !(held_q && code == hcode_q)) begin
                        disp_d   = {disp_q[23:0], code};
                        hist_d   = (hist_q == 3'(HIST_DEPTH)) ? hist_q : hist_q + 3'd1;
                        held_d   = 1'b1;
                        hcode_d  = code;
                        strobe_d = 1'b1;
                    end
                end
                S_BRK: begin
                    if (code == CODE_EXT) state_d = S_EXT;
                    else if (code != CODE_BRK) begin
                        state_d = S_IDLE;
                        if (code == hcode_q) begin
                            held_d  = 1'b0;
                            hcode_d = '0;
                        end
                    end
                end
                S_EXT:     state_d = (code == CODE_BRK) ? S_EXT_BRK : S_IDLE;
                S_EXT_BRK: state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end else if (timeout_hit) begin
            disp_d = '0;
            hist_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            disp_q   <= '0;
            hist_q   <= '0;
            held_q   <= 1'b0;
            hcode_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            disp_q   <= disp_d;
            hist_q   <= hist_d;
            held_q   <= held_d;
            hcode_q  <= hcode_d;
            strobe_q <= strobe_d;
        end
    end

    assign disp_word   = disp_q;
    assign hist_count  = hist_q;
    assign key_held    = held_q;
    assign held_code   = hcode_q;
    assign note_strobe = strobe_q;

endmodule

// File: tb/tb_note_hist_ctrl.sv
// Scoreboard bench for note_hist_ctrl: each expected note press is queued at
// stimulus time and checked by a monitor whenever note_strobe is seen.
module tb_note_hist_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        code_valid = 1'b0;
    logic [7:0]  code = '0;
    logic        clear = 1'b0;
    logic [31:0] disp_word;
    logic [2:0]  hist_count;
    logic        key_held;
    logic [7:0]  held_code;
    logic        note_strobe;

    typedef struct {
        logic [31:0] disp;
        logic [2:0]  cnt;
        logic [7:0]  held;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    note_hist_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .code_valid  (code_valid),
        .code        (code),
        .clear       (clear),
        .disp_word   (disp_word),
        .hist_count  (hist_count),
        .key_held    (key_held),
        .held_code   (held_code),
        .note_strobe (note_strobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #2 code_valid = 1'b1;
        code = b;
        @(posedge clk);
        #2 code_valid = 1'b0;
    endtask

    task automatic press(input logic [7:0] b, input logic [31:0] d, input logic [2:0] c);
        exp_t e;
        e.disp = d;
        e.cnt  = c;
        e.held = b;
        sb.push_back(e);
        send(b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_state(input string tag, input logic [31:0] d, input logic [2:0] c,
                               input logic k, input logic [7:0] h);
        check({tag, "_disp"}, disp_word, d);
        check({tag, "_cnt"}, 32'(hist_count), 32'(c));
        check({tag, "_held"}, 32'(key_held), 32'(k));
        check({tag, "_code"}, 32'(held_code), 32'(h));
        check({tag, "_pending"}, 32'(sb.size()), 32'd0);
    endtask

    // Monitor: every strobe must match the oldest queued press
    always @(negedge clk) begin
        if (rst_n && note_strobe) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_disp", disp_word, e.disp);
                check("strobe_cnt", 32'(hist_count), 32'(e.cnt));
                check("strobe_code", 32'(held_code), 32'(e.held));
                check("strobe_held", 32'(key_held), 32'd1);
            end
        end
    end

    initial begin
        idle(3);
        check_state("reset", 32'h0, 3'd0, 1'b0, 8'h00);
        check("reset_strobe", 32'(note_strobe), 32'd0);
        rst_n = 1'b1;
        idle(2);

        press(8'h1C, 32'h0000001C, 3'd1);
        idle(2);
        check_state("first", 32'h0000001C, 3'd1, 1'b1, 8'h1C);

        send(8'h1C);
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        idle(2);
        check_state("repeat_rel", 32'h0000001C, 3'd1, 1'b0, 8'h00);

        press(8'h15, 32'h00001C15, 3'd2); send(8'hF0); send(8'h15);
        press(8'h1D, 32'h001C151D, 3'd3); send(8'hF0); send(8'h1D);
        press(8'h24, 32'h1C151D24, 3'd4); send(8'hF0); send(8'h24);
        press(8'h2D, 32'h151D242D, 3'd4); send(8'hF0); send(8'h2D);
        press(8'h2C, 32'h1D242D2C, 3'd4); send(8'hF0); send(8'h2C);
        idle(2);
        check_state("sat", 32'h1D242D2C, 3'd4, 1'b0, 8'h00);

        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hF0); send(8'h22);
        idle(2);
        check_state("ext", 32'h1D242D2C, 3'd4, 1'b0, 8'h00);

        press(8'h1A, 32'h242D2C1A, 3'd4);
        send(8'hF0); send(8'hF0); send(8'h22);
        idle(2);
        check_state("rel_other", 32'h242D2C1A, 3'd4, 1'b1, 8'h1A);
        send(8'hE0); send(8'h1A);
        send(8'h1A);
        idle(2);
        check_state("ext_held", 32'h242D2C1A, 3'd4, 1'b1, 8'h1A);

        @(posedge clk);
        #2 code_valid = 1'b1; code = 8'h1A; clear = 1'b1;
        @(posedge clk);
        #2 code_valid = 1'b0; clear = 1'b0;
        idle(2);
        check_state("clear", 32'h0, 3'd0, 1'b0, 8'h00);
        check("clear_strobe", 32'(note_strobe), 32'd0);

        press(8'h3A, 32'h0000003A, 3'd1);
        send(8'hF0);
        #1 rst_n = 1'b0;
        #1;
        check_state("async_rst", 32'h0, 3'd0, 1'b0, 8'h00);
        idle(2);
        rst_n = 1'b1;
        press(8'h1A, 32'h0000001A, 3'd1);
        idle(2);
        check_state("post_rst", 32'h0000001A, 3'd1, 1'b1, 8'h1A);

        send(8'hF0); send(8'h1A);
        press(8'h3B, 32'h00001A3B, 3'd2);
        send(8'hF0); send(8'h3B);
        idle(20);
`ifdef NOTE_HIST_TIMEOUT_EN
        check_state("idle_rel", 32'h0, 3'd0, 1'b0, 8'h00);
        press(8'h3B, 32'h0000003B, 3'd1);
        idle(30);
        check_state("idle_held", 32'h0000003B, 3'd1, 1'b1, 8'h3B);
`else
        check_state("idle_rel", 32'h00001A3B, 3'd2, 1'b0, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
